// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - request/display signal bundle for vga_timing_gen
interface vga_timing_gen_if #(
  parameter int CW = 11
);
  // Request side: coordinate the source must fill, plus its pixel answer
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          req;
  logic          frame_start;
  logic [11:0]   pix_in;

  // Display side: one pixel period behind the request side
  logic          hsync;
  logic          vsync;
  logic          de;
  logic [11:0]   rgb;

  modport master (
    output x, y, req, frame_start, hsync, vsync, de, rgb,
    input  pix_in
  );

  modport slave (
    input  x, y, req, frame_start, hsync, vsync, de, rgb,
    output pix_in
  );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA timing generator with request/display pipeline (option: VGA_TEST_PATTERN_EN)
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIX_DIV  = 5,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  vga_timing_gen_if.master      bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_SS     = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SE     = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_SS     = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SE     = CW'(V_ACTIVE + V_FP + V_SYNC);

  // IDLE: stopped or just reset, counters parked at (0,0) with req low.
  // RUN : the first pixel tick after IDLE loads (0,0) and starts scanning.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t        state, state_nx;
  logic [DW-1:0] div, div_nx;
  logic [CW-1:0] h_cnt, v_cnt, h_nx, v_nx;
  logic          pix_ce;
  logic          req_nx;
  logic          fs_nx;
  logic          req_q;
  logic          fs_q;
  logic          h_in_sync;
  logic          v_in_sync;
  logic [11:0]   pix_color;

  // Pixel tick: last cycle of each divider period
  always_comb begin
    pix_ce = (div == DIV_LAST);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state, divider and raster counters; en low overrides everything
  always_comb begin
    state_nx = state;
    div_nx   = div;
    h_nx     = h_cnt;
    v_nx     = v_cnt;
    fs_nx    = 1'b0;
    if (!en) begin
      state_nx = ST_IDLE;
      div_nx   = '0;
      h_nx     = '0;
      v_nx     = '0;
    end else begin
      div_nx = pix_ce ? '0 : div + DW'(1);
      if (pix_ce) begin
        case (state)
          ST_IDLE: begin
            state_nx = ST_RUN;
            h_nx     = '0;
            v_nx     = '0;
            fs_nx    = 1'b1;
          end
          ST_RUN: begin
            if (h_cnt == H_LAST) begin
              h_nx = '0;
              if (v_cnt == V_LAST) begin
                v_nx  = '0;
                fs_nx = 1'b1;
              end else begin
                v_nx = v_cnt + CW'(1);
              end
            end else begin
              h_nx = h_cnt + CW'(1);
            end
          end
          default: begin
            state_nx = ST_IDLE;
          end
        endcase
      end
    end
  end

  // Request valid follows the coordinate loaded on the same edge
  always_comb begin
    req_nx = (state_nx == ST_RUN) && (h_nx < H_ACT) && (v_nx < V_ACT);
  end

  // Request-side registers: divider, counters, req and frame_start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div   <= '0;
      h_cnt <= '0;
      v_cnt <= '0;
      req_q <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      div   <= div_nx;
      h_cnt <= h_nx;
      v_cnt <= v_nx;
      req_q <= req_nx;
      fs_q  <= fs_nx;
    end
  end

  assign bus.x           = h_cnt;
  assign bus.y           = v_cnt;
  assign bus.req         = req_q;
  assign bus.frame_start = fs_q;

  // Sync windows evaluated on the request coordinate, registered one pixel later
  always_comb begin
    h_in_sync = (state == ST_RUN) && (h_cnt >= H_SS) && (h_cnt < H_SE);
    v_in_sync = (state == ST_RUN) && (v_cnt >= V_SS) && (v_cnt < V_SE);
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [CW+2:0] h_x8;
  logic [CW+2:0] bar_q;

  // Colour bar index = h*8/H_ACTIVE; the source pixel is not used
  always_comb begin
    h_x8  = {h_cnt, 3'b000};
    bar_q = h_x8 / (CW + 3)'(H_ACTIVE);
    case (bar_q[2:0])
      3'd0:    pix_color = 12'hFFF;
      3'd1:    pix_color = 12'hFF0;
      3'd2:    pix_color = 12'h0FF;
      3'd3:    pix_color = 12'h0F0;
      3'd4:    pix_color = 12'hF0F;
      3'd5:    pix_color = 12'hF00;
      3'd6:    pix_color = 12'h00F;
      default: pix_color = 12'h000;
    endcase
  end
`else
  // Pass the source pixel straight through to the display register
  always_comb begin
    pix_color = bus.pix_in;
  end
`endif

  // Display-side registers, advanced once per pixel tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.de    <= 1'b0;
      bus.rgb   <= 12'h000;
      bus.hsync <= ~HS_POL;
      bus.vsync <= ~VS_POL;
    end else if (!en) begin
      bus.de    <= 1'b0;
      bus.rgb   <= 12'h000;
      bus.hsync <= ~HS_POL;
      bus.vsync <= ~VS_POL;
    end else if (pix_ce) begin
      bus.de    <= req_q;
      bus.rgb   <= req_q ? pix_color : 12'h000;
      bus.hsync <= h_in_sync ? HS_POL : ~HS_POL;
      bus.vsync <= v_in_sync ? VS_POL : ~VS_POL;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;

  vga_timing_gen_if #(.CW(11)) bus ();

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .PIX_DIV(5), .HS_POL(1'b0), .VS_POL(1'b0), .CW(11)
  ) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int n, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s n=%0d observed %0h expected %0h", tag, n, obs, exp);
    end
  endtask

  // Advance to the next falling edge; the source answers for the current coordinate
  task automatic tick();
    @(negedge clk);
    bus.pix_in = {4'h0, bus.y[3:0], bus.x[3:0]};
  endtask

  task automatic check_idle(input int n);
    chk("x_idle", n, bus.x, 0);
    chk("y_idle", n, bus.y, 0);
    chk("req_idle", n, bus.req, 0);
    chk("fs_idle", n, bus.frame_start, 0);
    chk("de_idle", n, bus.de, 0);
    chk("rgb_idle", n, bus.rgb, 0);
    chk("hsync_idle", n, bus.hsync, 1);
    chk("vsync_idle", n, bus.vsync, 1);
  endtask

  // Expected outputs n clock edges after start (reset release or en rise)
  // H_TOTAL=16, V_TOTAL=8, first pixel tick at edge 5, one pixel per 5 clks
  task automatic check_at(input int n);
    int p, h, v, dp, dh, dv;
    logic [10:0] e_x, e_y;
    logic e_req, e_fs, e_de, e_hs, e_vs;
    logic [11:0] e_rgb;
    e_x = 0; e_y = 0; e_req = 0; e_fs = 0;
    e_de = 0; e_hs = 1; e_vs = 1; e_rgb = 0;
    p = 0;
    if (n >= 5) begin
      p = (n - 5) / 5;
      h = p % 16;
      v = (p / 16) % 8;
      e_x = 11'(h);
      e_y = 11'(v);
      e_req = (h < 8) && (v < 4);
      e_fs = ((n - 5) % 640) == 0;
    end
    if (n >= 10) begin
      dp = p - 1;
      dh = dp % 16;
      dv = (dp / 16) % 8;
      e_de = (dh < 8) && (dv < 4);
      e_hs = !((dh >= 10) && (dh < 13));
      e_vs = !((dv >= 5) && (dv < 7));
      e_rgb = e_de ? {4'h0, dv[3:0], dh[3:0]} : 12'h000;
    end
    chk("x", n, bus.x, e_x);
    chk("y", n, bus.y, e_y);
    chk("req", n, bus.req, e_req);
    chk("frame_start", n, bus.frame_start, e_fs);
    chk("de", n, bus.de, e_de);
    chk("rgb", n, bus.rgb, e_rgb);
    chk("hsync", n, bus.hsync, e_hs);
    chk("vsync", n, bus.vsync, e_vs);
  endtask

  initial begin
    bus.pix_in = 12'h000;

    // Reset state
    tick(); tick(); tick();
    check_idle(0);

    // Release reset with en=1, then run past one frame wrap to (h=12, v=6) of frame 2
    rst = 1'b1;
    for (int n = 1; n <= 1186; n++) begin
      tick();
      check_at(n);
    end
    chk("x_before_stop", 1186, bus.x, 12);
    chk("y_before_stop", 1186, bus.y, 6);
    chk("hsync_before_stop", 1186, bus.hsync, 0);
    chk("vsync_before_stop", 1186, bus.vsync, 0);

    // Drop en mid-pixel: everything inactive after one edge, and holds
    en = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check_idle(k);
    end

    // Raise en: restart from (0,0), frame_start five clocks later
    en = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      tick();
      check_at(n);
    end
    chk("x_before_rst", 100, bus.x, 3);
    chk("req_before_rst", 100, bus.req, 1);

    // Asynchronous reset pulse away from the clock edge
    #2;
    rst = 1'b0;
    #1;
    check_idle(-1);
    tick();
    check_idle(-2);

    // Release: behaves as a fresh start
    rst = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      check_at(n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; parameters (name, default, meaning) SHALL be:
  H_ACTIVE 640 visible pixels/line; H_FP 16 front porch; H_SYNC 96 sync width; H_BP 48 back porch.
  V_ACTIVE 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33.
  PIX_DIV 5 clk cycles per pixel (>=1); HS_POL 0 / VS_POL 0, where 0 means active-low sync; CW 11 counter/coordinate width.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
  clk  in  1  system clock.
  rst  in  1  asynchronous reset, active-low.
  en  in  1  timing run enable.
  pix_in  in  12  RGB444 pixel from the source for the current request coordinate.
  x  out  CW  request column.
  y  out  CW  request row.
  req  out  1  request valid; high while the request coordinate is active.
  frame_start  out  1  one-clk pulse at request coordinate (0,0).
  hsync  out  1  display-side horizontal sync.
  vsync  out  1  display-side vertical sync.
  de  out  1  display-side data enable.
  rgb  out  12  display-side pixel.

Function
REQ-003 Divider: div counts 0..PIX_DIV-1 and wraps; pix_ce=1 for one clk when div==PIX_DIV-1; PIX_DIV=1 SHALL give pix_ce=1 every cycle.
REQ-004 On pix_ce, h_cnt SHALL advance 0..H_TOTAL-1, with H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP.
REQ-005 On pix_ce with h_cnt==H_TOTAL-1, h_cnt SHALL wrap to 0 and v_cnt SHALL advance 0..V_TOTAL-1, wrapping to 0 after V_TOTAL-1.
REQ-006 x/y SHALL equal h_cnt/v_cnt; req SHALL be (h_cnt<H_ACTIVE && v_cnt<V_ACTIVE), updated in the same edge as the counters.
REQ-007 frame_start SHALL be 1 for exactly one clk: the cycle after the pix_ce edge that loads h_cnt=0, v_cnt=0.
REQ-008 The source SHALL present pix_in valid for the coordinate (x,y) by the pix_ce cycle that ends that coordinate; the block SHALL sample pix_in on that pix_ce.
REQ-009 Display side SHALL lag the request side by exactly one pixel period (one pix_ce), registered on pix_ce.
REQ-010 de SHALL be the delayed req; rgb SHALL be the sampled pix_in when req was 1, else 12'h000.
REQ-011 hsync SHALL be active while the delayed h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync SHALL be active while the delayed v_cnt is in the matching vertical window.
REQ-012 Active level SHALL be HS_POL/VS_POL; the inactive level SHALL be its complement.
REQ-013 en=0 SHALL synchronously clear div, h_cnt and v_cnt to 0; req and frame_start SHALL be 0, display outputs SHALL go inactive (de=0, rgb=0, syncs inactive) on the next clk, and all SHALL hold.
REQ-014 en 0->1 SHALL resume from (0,0), with the first pix_ce PIX_DIV clks later and frame_start following per REQ-007.
REQ-015 A frame wrap coinciding with en falling: en=0 SHALL take priority.

Reset
REQ-016 rst=0 SHALL asynchronously force div=h_cnt=v_cnt=0, x=y=0, req=0, frame_start=0, de=0, rgb=0, hsync=~HS_POL, vsync=~VS_POL.
REQ-017 Reset deassertion SHALL behave as en 0->1 if en=1.
REQ-018 Reset asserted mid-line or mid-frame SHALL discard all pipeline state.

Configuration
REQ-019 With VGA_TEST_PATTERN_EN defined, rgb during de SHALL be an 8-bar colour pattern selected by delayed h_cnt*8/H_ACTIVE: white, yellow, cyan, green, magenta, red, blue, black (RGB444 full-scale values); pix_in SHALL be ignored.
REQ-020 Without VGA_TEST_PATTERN_EN, rgb SHALL follow REQ-010; no pattern logic SHALL be synthesised.

Verification (small params: H 8/2/3/3 giving H_TOTAL=16; V 4/1/2/1 giving V_TOTAL=8; PIX_DIV=5; HS_POL=VS_POL=0)
REQ-021 Reset release with en=1 -> frame_start at clk 5; pix_ce period 5 clks; line period 80 clks; frame period 640 clks.
REQ-022 Sweep one line -> req high for 8 pixels (x=0..7); hsync low for 3 pixels starting at display h=10; de/hsync trail req/x by exactly 5 clks.
REQ-023 pix_in={4'h0,y[3:0],x[3:0]} -> rgb equals that value one pixel later during de; rgb=0 outside de.
REQ-024 Frame boundary -> vsync low for lines 5..6 only; y wraps 7->0 with frame_start once per frame.
REQ-025 en dropped at h=12,v=6, then raised 20 clks later -> outputs inactive within 1 clk; restart at (0,0) with frame_start 5 clks after en rises.
REQ-026 Async rst pulse mid-line, not clk-aligned -> all outputs at reset values immediately; hsync=vsync=1.
